// File: rtl/sa_drain_collector_pkg.sv
// Shared types and constants for the systolic-array drain collector.
// Array geometry comes from the DIMENSION / BIT_W defines.
`ifndef DIMENSION
`define DIMENSION 4
`endif
`ifndef BIT_W
`define BIT_W 16
`endif

package sa_drain_collector_pkg;

    localparam int SA_DIM   = `DIMENSION;
    localparam int SA_BIT_W = `BIT_W;
    localparam int CNT_W    = $clog2(2 * SA_DIM);

    typedef logic [`DIMENSION-1:0][`BIT_W-1:0] sa_row_t;

    typedef enum logic {DR_IDLE, DR_DRAIN} drain_state_e;

    typedef struct packed {
        logic    last;
        sa_row_t row;
    } row_entry_t;

    // cnt holds the previous edge index during DRAIN, so these mark edges D and 2D-1.
    localparam logic [CNT_W-1:0] CNT_WR_FIRST = CNT_W'(SA_DIM - 1);
    localparam logic [CNT_W-1:0] CNT_WR_LAST  = CNT_W'(2 * SA_DIM - 2);

    function automatic logic cnt_in_write_window(input logic [CNT_W-1:0] cnt);
        return cnt >= CNT_WR_FIRST;
    endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// First-word-fall-through row FIFO; pop data is zero while empty.
// Latency: a pushed entry is visible the cycle after the push. Pop on vld && rdy.
module sa_row_fifo #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             pop_vld_o,
    input  logic             pop_rdy_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic [CW-1:0]    free_cnt_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop;

    assign pop_vld_o  = (count_q != '0);
    assign pop        = pop_vld_o && pop_rdy_i;
    assign pop_dat_o  = pop_vld_o ? mem_q[rd_ptr_q] : '0;
    assign free_cnt_o = CW'(DEPTH) - count_q;

    always_ff @(posedge clk) begin
        if (push_vld_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_vld_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_vld_i, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Writers must check free_cnt_o before committing a burst; a full push is a design error.
    assert property (@(posedge clk) disable iff (rst) !(push_vld_i && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/sa_drain_collector.sv
// De-skews the array's bottom-edge psum stream into whole rows and queues them for writeback.
// Row r appears on m_data after edge r+D; a tile is admitted only when the FIFO can take all D rows.
module sa_drain_collector
    import sa_drain_collector_pkg::*;
#(
    parameter int FIFO_DEPTH = 2 * SA_DIM
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    output logic    start_rdy,
    input  sa_row_t sa_bot,
    output logic    m_valid,
    input  logic    m_ready,
    output sa_row_t m_data,
    output logic    m_last,
    output logic    busy,
    output logic    done
);

    localparam int                FREE_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [FREE_W-1:0] ROWS_NEEDED = FREE_W'(SA_DIM);

    drain_state_e     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    sa_row_t          aligned;
    row_entry_t       push_entry;
    row_entry_t       pop_entry;
    logic             push_vld;
    logic [FREE_W-1:0] free_cnt;

    // Column j arrives j cycles late; delaying it D-1-j cycles lines every column up.
    for (genvar j = 0; j < SA_DIM - 1; j++) begin : g_dly
        localparam int DEPTH = SA_DIM - 1 - j;
        logic [DEPTH-1:0][SA_BIT_W-1:0] line_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                line_q <= '0;
            end else begin
                line_q[0] <= sa_bot[j];
                for (int s = 1; s < DEPTH; s++) begin
                    line_q[s] <= line_q[s-1];
                end
            end
        end

        assign aligned[j] = line_q[DEPTH-1];
    end
    assign aligned[SA_DIM-1] = sa_bot[SA_DIM-1];

    assign start_rdy = (state_q == DR_IDLE) && (free_cnt >= ROWS_NEEDED);
    assign busy      = (state_q == DR_DRAIN);
    assign done      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DR_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DR_IDLE: begin
                    if (start && start_rdy) begin
                        state_q <= DR_DRAIN;
                        cnt_q   <= '0;
                    end
                end
                DR_DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_WR_LAST) begin
                        state_q <= DR_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= DR_IDLE;
            endcase
        end
    end

    always_comb begin
        push_vld        = (state_q == DR_DRAIN) && cnt_in_write_window(cnt_q);
        push_entry.row  = aligned;
        push_entry.last = (cnt_q == CNT_WR_LAST);
    end

    sa_row_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(row_entry_t))
    ) u_row_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (push_vld),
        .push_dat_i (push_entry),
        .pop_vld_o  (m_valid),
        .pop_rdy_i  (m_ready),
        .pop_dat_o  (pop_entry),
        .free_cnt_o (free_cnt)
    );

    assign m_data = pop_entry.row;
    assign m_last = pop_entry.last;

endmodule

// File: tb/tb_sa_drain_collector.sv
// Directed bench for sa_drain_collector at D=4, BIT_W=16, FIFO_DEPTH=8.
// A background driver plays the array's skewed bottom-edge stream after every accepted start.
module tb_sa_drain_collector;
    import sa_drain_collector_pkg::*;

    localparam int D  = SA_DIM;
    localparam int NT = 20;

    logic    clk;
    logic    rst;
    logic    start;
    logic    start_rdy;
    sa_row_t sa_bot;
    logic    m_valid;
    logic    m_ready;
    sa_row_t m_data;
    logic    m_last;
    logic    busy;
    logic    done;

    int n_cmp;
    int n_err;

    sa_drain_collector #(.FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_rdy (start_rdy),
        .sa_bot    (sa_bot),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic sa_row_t exp_row(input int r);
        sa_row_t v;
        for (int j = 0; j < D; j++) begin
            v[j] = SA_BIT_W'(256 * r + j);
        end
        return v;
    endfunction

    // Array model: element (r,j) is presented for sampling edge r+j+1 after acceptance edge 0.
    initial begin : skew_drv
        int   ph;
        int   r;
        logic acc;
        ph  = 0;
        acc = 1'b0;
        for (int j = 0; j < D; j++) sa_bot[j] = SA_BIT_W'(16'hDEAD);
        forever begin
            @(negedge clk);
            acc = start && start_rdy && !rst;
            @(posedge clk);
            #1;
            if (rst) ph = 0;
            else if (acc) ph = 1;
            else if (ph >= 1 && ph < 2 * D - 1) ph = ph + 1;
            else ph = 0;
            for (int j = 0; j < D; j++) begin
                r = ph - 1 - j;
                sa_bot[j] = (ph >= 1 && r >= 0 && r < D) ? SA_BIT_W'(256 * r + j) : SA_BIT_W'(16'hDEAD);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_cmp++; if (start_rdy !== 1'b1) begin n_err++; $display("FAIL reset_start_rdy: got %b expected 1", start_rdy); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL reset_m_data: got %h expected 0", m_data); end
        n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_tile();
        m_ready = 1'b1;
        start   = 1'b1;
        n_cmp++; if (start_rdy !== 1'b1) begin n_err++; $display("FAIL single_start_rdy: got %b expected 1", start_rdy); end
        tick();
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
        for (int k = 1; k <= 2 * D - 1; k++) begin
            tick();
            if (k >= D) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== exp_row(k - D) || m_last !== (k == 2 * D - 1)) begin
                    n_err++;
                    $display("FAIL single_row edge %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, m_valid, m_data, m_last, exp_row(k - D), (k == 2 * D - 1));
                end
            end else begin
                n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_early edge %0d: got m_valid=%b expected 0", k, m_valid); end
            end
            if (k < 2 * D - 1) begin
                n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_early edge %0d: got %b expected 0", k, done); end
            end
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL single_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
        tick();
        n_cmp++; if (done !== 1'b0 || m_valid !== 1'b0) begin n_err++; $display("FAIL single_after: got done=%b m_valid=%b expected 0 0", done, m_valid); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        start   = 1'b1;
        tick();
        repeat (2 * D - 1) tick();
        n_cmp++; if (busy !== 1'b0 || start_rdy !== 1'b1) begin n_err++; $display("FAIL bp_tile1_end: got busy=%b start_rdy=%b expected 0 1", busy, start_rdy); end
        n_cmp++; if (m_valid !== 1'b1 || m_data !== exp_row(0)) begin n_err++; $display("FAIL bp_head: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, exp_row(0)); end
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_tile2_accept: got busy=%b expected 1", busy); end
        repeat (2 * D - 1) tick();
        n_cmp++; if (start_rdy !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_full: got start_rdy=%b busy=%b expected 0 0", start_rdy, busy); end
        repeat (2) tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_third_ignored: got busy=%b expected 0", busy); end
        start = 1'b0;
        for (int p = 0; p < 2 * D; p++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || m_data !== exp_row(p % D) || m_last !== (p % D == D - 1)) begin
                n_err++;
                $display("FAIL bp_pop %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", p, m_valid, m_data, m_last, exp_row(p % D), (p % D == D - 1));
            end
            m_ready = 1'b1;
            tick();
            m_ready = 1'b0;
            if (p == 0) begin
                n_cmp++; if (start_rdy !== 1'b0) begin n_err++; $display("FAIL bp_one_pop: got start_rdy=%b expected 0", start_rdy); end
            end
            if (p == 3) begin
                n_cmp++; if (start_rdy !== 1'b1) begin n_err++; $display("FAIL bp_four_pops: got start_rdy=%b expected 1", start_rdy); end
            end
        end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got m_valid=%b expected 0", m_valid); end
    endtask

    task automatic test_random_backpressure();
        int accepted, rx, lasts, cyc;
        accepted = 0; rx = 0; lasts = 0; cyc = 0;
        while (rx < D * NT && cyc < 4000) begin
            start   = (accepted < NT);
            m_ready = 1'($urandom_range(0, 1));
            if (start && start_rdy) accepted++;
            if (m_valid && m_ready) begin
                n_cmp++;
                if (m_data !== exp_row(rx % D) || m_last !== (rx % D == D - 1)) begin
                    n_err++;
                    $display("FAIL rand_row %0d: got d=%h l=%b expected d=%h l=%b", rx, m_data, m_last, exp_row(rx % D), (rx % D == D - 1));
                end
                if (m_last) lasts++;
                rx++;
            end
            tick();
            cyc++;
        end
        start   = 1'b0;
        m_ready = 1'b1;
        n_cmp++; if (rx != D * NT) begin n_err++; $display("FAIL rand_rows_received: got %0d expected %0d", rx, D * NT); end
        n_cmp++; if (lasts != NT) begin n_err++; $display("FAIL rand_last_count: got %0d expected %0d", lasts, NT); end
        n_cmp++; if (accepted != NT) begin n_err++; $display("FAIL rand_tiles_accepted: got %0d expected %0d", accepted, NT); end
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rand_empty: got m_valid=%b expected 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        int acc_n;
        int ph;
        acc_n   = 1;
        m_ready = 1'b1;
        start   = 1'b1;
        n_cmp++; if (start_rdy !== 1'b1) begin n_err++; $display("FAIL b2b_first_rdy: got %b expected 1", start_rdy); end
        tick();
        for (int c = 0; c < 3 * 2 * D; c++) begin
            ph = c % (2 * D);
            n_cmp++; if (busy !== (ph != 2 * D - 1)) begin n_err++; $display("FAIL b2b_busy edge %0d: got %b expected %b", c, busy, (ph != 2 * D - 1)); end
            n_cmp++; if (start_rdy !== (ph == 2 * D - 1)) begin n_err++; $display("FAIL b2b_start_rdy edge %0d: got %b expected %b", c, start_rdy, (ph == 2 * D - 1)); end
            if (ph >= D) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== exp_row(ph - D)) begin
                    n_err++;
                    $display("FAIL b2b_row edge %0d: got v=%b d=%h expected v=1 d=%h", c, m_valid, m_data, exp_row(ph - D));
                end
            end else begin
                n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap edge %0d: got m_valid=%b d=%h expected 0", c, m_valid, m_data); end
            end
            if (c == 3 * 2 * D - 1) start = 1'b0;
            else if (start && start_rdy) acc_n++;
            tick();
        end
        n_cmp++; if (acc_n != 3) begin n_err++; $display("FAIL b2b_acceptances: got %0d expected 3", acc_n); end
    endtask

    task automatic test_reset_mid_drain();
        m_ready = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        n_cmp++; if (m_valid !== 1'b1 || busy !== 1'b1 || m_data !== exp_row(0)) begin n_err++; $display("FAIL mid_pre: got v=%b busy=%b d=%h expected 1 1 %h", m_valid, busy, m_data, exp_row(0)); end
        rst = 1'b1;
        #1;
        n_cmp++; if (start_rdy !== 1'b1) begin n_err++; $display("FAIL mid_start_rdy: got %b expected 1", start_rdy); end
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_m_valid: got %b expected 0", m_valid); end
        n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL mid_m_data: got %h expected 0", m_data); end
        n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL mid_m_last: got %b expected 0", m_last); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b expected 0", done); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (m_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_post: got v=%b busy=%b expected 0 0", m_valid, busy); end
        m_ready = 1'b1;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 2 * D - 1; k++) begin
            tick();
            if (k >= D) begin
                n_cmp++;
                if (m_valid !== 1'b1 || m_data !== exp_row(k - D) || m_last !== (k == 2 * D - 1)) begin
                    n_err++;
                    $display("FAIL mid_retile edge %0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", k, m_valid, m_data, m_last, exp_row(k - D), (k == 2 * D - 1));
                end
            end
        end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mid_retile_done: got %b expected 1", done); end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_tile();
        test_backpressure();
        test_random_backpressure();
        test_back_to_back();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sa_drain_collector.md
# sa_drain_collector

Output-side companion to the systolic array. After a tile is computed, the array emits partial sums on its bottom edge skewed by one cycle per column. This block samples that skewed stream and re-aligns it into whole rows. It buffers the rows in a FIFO and presents them on a valid/ready stream to the writeback path. It is the receive end of the skew protocol that the array's input feeders transmit.

## Interface
- `DIMENSION`, `` `DIMENSION `` (DEFINE_PKG), array edge length D, ≥2
- `BIT_W`, `` `BIT_W `` (DEFINE_PKG), psum width
- `FIFO_DEPTH`, 2*DIMENSION, row-FIFO entries, ≥DIMENSION, power of 2
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request to drain one tile.
- `start_rdy` out 1: the drain can be accepted.
- `sa_bot` in D×BIT_W: array bottom-edge psums (`out_bot`).
- `m_valid` out 1: an aligned row is available.
- `m_ready` in 1: downstream accepts the row.
- `m_data` out D×BIT_W: aligned row, column j in slot j.
- `m_last` out 1: marks the final row (row D-1) of a tile.
- `busy` out 1: the FSM is in DRAIN.
- `done` out 1: one-cycle pulse when the last row is written to the FIFO.

## Operation
- FSM states IDLE → DRAIN → IDLE.
  - IDLE→DRAIN on an edge where `start && start_rdy`; that edge is edge 0.
  - DRAIN→IDLE on edge 2D-1.
- `start_rdy` = IDLE && (FIFO free entries ≥ D). The array cannot be stalled, so a tile is accepted only when the FIFO can hold all D rows. While in DRAIN, `start` is ignored.
- Edge counter `cnt`: cleared on acceptance, increments every DRAIN cycle, range 1..2D-1, width clog2(2D).
- Skew contract: the row-r, column-j psum is valid on `sa_bot[j]` for the sampling edge r+j+1 (r,j in 0..D-1).
- Column j passes through a free-running delay line D-1-j registers deep; column D-1 is not delayed. At edge r+D all D columns of row r are coincident.
- FIFO write on edges D..2D-1, giving rows 0..D-1 in order. `m_last` is stored with each entry and is 1 only for row D-1.
- `done` asserts for one cycle after edge 2D-1, simultaneously with `busy` falling.
- FIFO is first-word-fall-through.
  - `m_valid` = not empty.
  - A pop happens on `m_valid && m_ready`.
  - A push and a pop on the same edge leave the occupancy unchanged.
- Overflow cannot occur by construction (admission check). An underflow pop is impossible because `m_ready` with `m_valid` low has no effect.
- Data passes through bit-exact: no arithmetic, no width change.
- `rst` mid-DRAIN discards the partial tile and FIFO contents.

## Timing
- Reset values:
  - `start_rdy`=1 (after reset, the FIFO is empty).
  - `m_valid`=0, `m_data`=0, `m_last`=0.
  - `busy`=0, `done`=0.
  - FSM=IDLE, `cnt`=0, delay lines=0, FIFO pointers=0.
- Latency: row r is visible on `m_data` after edge r+D, if the FIFO was empty and undrained.
- A tile occupies DRAIN for 2D-1 cycles. Back-to-back tiles have a minimum spacing of 2D cycles from one acceptance to the next.
- `start_rdy` is combinational from state and FIFO occupancy, registered-source only. There is no combinational path from `m_ready` to `m_valid`.

## Structure
- DEFINE_PKG adds:
  - `typedef logic [`DIMENSION-1:0][`BIT_W-1:0] sa_row_t`
  - `typedef enum logic {DR_IDLE, DR_DRAIN} drain_state_e`
- The natural sub-module is `sa_row_fifo`: a synchronous FWFT FIFO over {`sa_row_t`, last}, parameterised by depth, exposing a free-count output.
- The delay lines and FSM stay in the top-level block.

## Test plan
All cases use D=4, BIT_W=16. The stimulus drives `sa_bot[j]` at edge r+j+1 with 16'h0100*r+j; all other cycles are 16'hDEAD.
- Single tile, `m_ready`=1 → `m_data` rows {0000,0001,0002,0003} … {0300,…,0303} appear after edges 4,5,6,7. `m_last` is set only on the last row. `done` pulses after edge 7.
- `m_ready`=0 with FIFO_DEPTH=8:
  - After tile 1 the occupancy is 4, so `start_rdy`=1 and tile 2 is accepted at the minimum spacing.
  - After tile 2, `start_rdy`=0 and a third `start` is ignored.
  - A single pop does not reassert `start_rdy` (free 1 < 4); four pops reassert it.
- Random `m_ready` backpressure over 20 tiles → all rows arrive in order and unmodified, with exactly one `m_last` per 4 rows.
- `start` held high continuously → acceptances occur every 8 cycles, `busy` has gaps of one cycle, and DEAD values never reach `m_data`.
- Assert `rst` at edge 5 of DRAIN → all outputs return to their reset values immediately (asynchronously), the partial rows are lost, and a subsequent tile drains correctly.
